// File: rtl/xspi_trk_pkg.sv
// Shared types and helpers for the xSPI page-boundary / tCEM split tracker.
// Burst-type and split-cause encodings, FSM states, page-mask decode.
package xspi_trk_pkg;

  localparam logic [1:0] BTYPE_INCR = 2'b01;
  localparam logic [1:0] BTYPE_WRAP = 2'b10;

  localparam logic [1:0] CAUSE_PAGE = 2'b01;
  localparam logic [1:0] CAUSE_TCEM = 2'b10;

  localparam logic [3:0] PG_CODE_MIN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_SPLIT = 2'd2
  } trk_state_e;

  function automatic int dqs_cnt_width(input int data_w);
    if (data_w >= 128) return 12;
    if (data_w >= 64) return 11;
    return 10;
  endfunction

  // Zero mask means the page check is disabled (codes below 6).
  function automatic logic [15:0] page_mask(input logic [3:0] code);
    logic [15:0] m;
    m = '0;
    if (code >= PG_CODE_MIN) m = (16'd1 << code) - 16'd1;
    return m;
  endfunction

endpackage

// File: rtl/xfer_addr_adv.sv
// Combinational address advance (INCR / WRAP / post-wrap jump)
// and page-boundary hit detect for the split tracker.
module xfer_addr_adv
  import xspi_trk_pkg::*;
#(
  parameter int AW            = 32,
  parameter int BYTES_PER_CLK = 2,
  parameter int PIPE_LEAD     = 2
) (
  input  logic [AW-1:0] addr_i,
  input  logic          lead_i,
  input  logic          wrap_en_i,
  input  logic [6:0]    wrap_mask_i,
  input  logic          cnt_zero_i,
  input  logic [3:0]    pg_code_i,
  output logic [AW-1:0] next_o,
  output logic          page_hit_o
);

  logic [AW-1:0] step;
  logic [AW-1:0] wmask;
  logic [AW-1:0] inc;
  logic [AW-1:0] wrapped;
  logic [AW-1:0] post;
  logic [15:0]   pmask;

  assign step = lead_i ? AW'(PIPE_LEAD * BYTES_PER_CLK)
                       : AW'(BYTES_PER_CLK);

  assign wmask   = AW'(wrap_mask_i);
  assign inc     = addr_i + step;
  assign wrapped = (addr_i & ~wmask) | (inc & wmask);
  // Wrap finished: resume linearly just past the wrap block.
  assign post    = (addr_i & ~wmask) + wmask + AW'(1);

  always_comb begin
    next_o = inc;
    if (wrap_en_i) next_o = cnt_zero_i ? post : wrapped;
  end

  assign pmask      = page_mask(pg_code_i);
  assign page_hit_o = (pmask != '0) &&
                      ((addr_i[15:0] & pmask) == '0);

endmodule

// File: rtl/xfer_split_tracker.sv
// Tracks live xSPI write address; requests split on page crossing or tCEM.
// Define RD_TRACK_EN to also track reads (tCEM-only splits for reads).
module xfer_split_tracker
  import xspi_trk_pkg::*;
#(
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int AXI_DATA_WIDTH = 32,
  parameter  int BYTES_PER_CLK  = 2,
  parameter  int PIPE_LEAD      = 2,
  localparam int DQS_CNT_WIDTH  = dqs_cnt_width(AXI_DATA_WIDTH)
) (
  input  logic                      mem_clk,
  input  logic                      rst_n,
  input  logic                      tcem_expired,
  input  logic [3:0]                mem_page_size,
  input  logic                      start_track,
  input  logic [AXI_ADDR_WIDTH-1:0] first_addr,
  input  logic                      wr_rd,
  input  logic [1:0]                xfer_btype,
  input  logic [DQS_CNT_WIDTH-1:0]  xfer_mem_len,
  input  logic                      sclk_en,
  input  logic                      ce_n_ip,
  output logic                      split_req,
  output logic [1:0]                split_cause,
  output logic [AXI_ADDR_WIDTH-1:0] resume_addr,
  input  logic                      split_ack,
  output logic                      xfer_done
);

  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int DW   = DQS_CNT_WIDTH;
  localparam int WB_W = DW + 4;

`ifdef RD_TRACK_EN
  localparam bit RD_TRACK = 1'b1;
`else
  localparam bit RD_TRACK = 1'b0;
`endif

  trk_state_e    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic [6:0]    wmask_q, wmask_d;
  logic          rd_q, rd_d;
  logic [1:0]    cause_q, cause_d;
  logic [AW-1:0] resume_q, resume_d;
  logic          done_q, done_d;

  logic [WB_W-1:0] wbytes;
  logic            wrap_ok;
  logic [6:0]      wmask_new;
  logic            idle;
  logic            cnt_zero;
  logic [AW-1:0]   adv_addr;
  logic            adv_wrap;
  logic [6:0]      adv_mask;
  logic            adv_czero;
  logic [AW-1:0]   adv_next;
  logic            page_hit;
  logic            pg_split;
  logic            accept;

  assign wbytes = WB_W'(xfer_mem_len) * WB_W'(BYTES_PER_CLK);

  // Only 16/32/64-byte wraps are honoured; anything else runs as INCR.
  assign wrap_ok = (xfer_btype == BTYPE_WRAP) &&
                   ((wbytes == WB_W'(16)) ||
                    (wbytes == WB_W'(32)) ||
                    (wbytes == WB_W'(64)));

  assign wmask_new = wbytes[6:0] - 7'd1;

  assign idle      = (state_q == ST_IDLE);
  assign cnt_zero  = (cnt_q == '0);
  assign adv_addr  = idle ? first_addr : addr_q;
  assign adv_wrap  = idle ? wrap_ok : wrap_q;
  assign adv_mask  = idle ? wmask_new : wmask_q;
  assign adv_czero = idle ? 1'b0 : cnt_zero;

  xfer_addr_adv #(
    .AW            (AW),
    .BYTES_PER_CLK (BYTES_PER_CLK),
    .PIPE_LEAD     (PIPE_LEAD)
  ) u_adv (
    .addr_i      (adv_addr),
    .lead_i      (idle),
    .wrap_en_i   (adv_wrap),
    .wrap_mask_i (adv_mask),
    .cnt_zero_i  (adv_czero),
    .pg_code_i   (mem_page_size),
    .next_o      (adv_next),
    .page_hit_o  (page_hit)
  );

  // A wrap still in progress must not be cut at a page boundary.
  assign pg_split = page_hit && !rd_q && (!wrap_q || cnt_zero);
  assign accept   = start_track && (wr_rd || RD_TRACK);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wrap_d   = wrap_q;
    wmask_d  = wmask_q;
    rd_d     = rd_q;
    cause_d  = cause_q;
    resume_d = resume_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_TRACK;
          addr_d  = adv_next;
          cnt_d   = xfer_mem_len - DW'(1);
          wrap_d  = wrap_ok;
          wmask_d = wrap_ok ? wmask_new : 7'd0;
          rd_d    = ~wr_rd;
        end
      end
      ST_TRACK: begin
        if (ce_n_ip) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tcem_expired) begin
          resume_d = sclk_en ? addr_q
                             : addr_q - AW'(BYTES_PER_CLK);
          cause_d  = CAUSE_TCEM |
                     (pg_split ? CAUSE_PAGE : 2'b00);
          state_d  = ST_SPLIT;
        end else if (!sclk_en) begin
          state_d = ST_TRACK;
        end else if (pg_split) begin
          resume_d = addr_q;
          cause_d  = CAUSE_PAGE;
          state_d  = ST_SPLIT;
        end else begin
          addr_d = adv_next;
          cnt_d  = cnt_zero ? '0 : cnt_q - DW'(1);
          if (cnt_zero) wrap_d = 1'b0;
        end
      end
      ST_SPLIT: begin
        if (split_ack || ce_n_ip) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      wmask_q  <= '0;
      rd_q     <= 1'b0;
      cause_q  <= '0;
      resume_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      wmask_q  <= wmask_d;
      rd_q     <= rd_d;
      cause_q  <= cause_d;
      resume_q <= resume_d;
      done_q   <= done_d;
    end
  end

  assign split_req   = (state_q == ST_SPLIT);
  assign split_cause = cause_q;
  assign resume_addr = resume_q;
  assign xfer_done   = done_q;

endmodule

// File: tb/tb_xfer_split_tracker.sv
// Bench for xfer_split_tracker: vector table plus corner sequences,
// split/done events checked through an expectation queue.
module tb_xfer_split_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tcem_expired;
  logic [3:0]  mem_page_size;
  logic        start_track;
  logic [31:0] first_addr;
  logic        wr_rd;
  logic [1:0]  xfer_btype;
  logic [9:0]  xfer_mem_len;
  logic        sclk_en;
  logic        ce_n_ip;
  logic        split_req;
  logic [1:0]  split_cause;
  logic [31:0] resume_addr;
  logic        split_ack;
  logic        xfer_done;

  always #5 clk = ~clk;

  xfer_split_tracker #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .BYTES_PER_CLK  (2),
    .PIPE_LEAD      (2)
  ) dut (
    .mem_clk       (clk),
    .rst_n         (rst_n),
    .tcem_expired  (tcem_expired),
    .mem_page_size (mem_page_size),
    .start_track   (start_track),
    .first_addr    (first_addr),
    .wr_rd         (wr_rd),
    .xfer_btype    (xfer_btype),
    .xfer_mem_len  (xfer_mem_len),
    .sclk_en       (sclk_en),
    .ce_n_ip       (ce_n_ip),
    .split_req     (split_req),
    .split_cause   (split_cause),
    .resume_addr   (resume_addr),
    .split_ack     (split_ack),
    .xfer_done     (xfer_done)
  );

  typedef struct {
    logic        kind;
    logic [1:0]  cause;
    logic [31:0] resume;
  } exp_t;

  typedef struct {
    logic [31:0] first;
    logic [3:0]  pg;
    logic [9:0]  len;
    logic [1:0]  bt;
    int          k;
    logic [31:0] res;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];
  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (split_req === 1'b1 && prev_req !== 1'b1) begin
      if (sb.size() == 0 || sb[0].kind != 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_split: unexpected split cause %b resume 0x%0h",
                 split_cause, resume_addr);
      end else begin
        e = sb.pop_front();
        check("sb_cause", {30'd0, split_cause}, {30'd0, e.cause});
        check("sb_resume", resume_addr, e.resume);
      end
    end
    if (xfer_done !== 1'b0) begin
      n_cmp++;
      if (sb.size() == 0 || sb[0].kind != 1'b1) begin
        n_err++;
        $display("FAIL sb_done: unexpected xfer_done %b", xfer_done);
      end else begin
        e = sb.pop_front();
      end
    end
    prev_req = split_req;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic start(input logic [31:0] a, input logic [3:0] pg,
                       input logic [1:0] bt, input logic [9:0] len,
                       input logic wr);
    first_addr    = a;
    mem_page_size = pg;
    xfer_btype    = bt;
    xfer_mem_len  = len;
    wr_rd         = wr;
    start_track   = 1'b1;
    tick();
    start_track   = 1'b0;
  endtask

  task automatic ack();
    split_ack = 1'b1;
    tick();
    split_ack = 1'b0;
    check("ack_drop", split_req, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; tcem_expired = 1'b0; mem_page_size = 4'd0;
    start_track = 1'b0; first_addr = '0; wr_rd = 1'b1;
    xfer_btype = 2'b01; xfer_mem_len = 10'd32; sclk_en = 1'b1;
    ce_n_ip = 1'b0; split_ack = 1'b0;

    vt[0] = '{32'h30, 4'd6, 10'd32, 2'b01, 7, 32'h40};
    vt[1] = '{32'h7C, 4'd7, 10'd32, 2'b01, 1, 32'h80};
    vt[2] = '{32'h3F0, 4'd10, 10'd32, 2'b01, 7, 32'h400};
    vt[3] = '{32'hFFFF_FFF8, 4'd6, 10'd32, 2'b01, 3, 32'h0};
    vt[4] = '{32'h1C, 4'd6, 10'd8, 2'b10, 25, 32'h40};
    vt[5] = '{32'h4C, 4'd6, 10'd8, 2'b10, 33, 32'h80};
    vt[6] = '{32'h58, 4'd6, 10'd16, 2'b10, 33, 32'h80};
    vt[7] = '{32'h3C, 4'd6, 10'd4, 2'b10, 1, 32'h40};
    vt[8] = '{32'h100, 4'd5, 10'd32, 2'b01, 0, 32'h0};

    repeat (3) tick();
    check("rst_req", split_req, 0);
    check("rst_cause", split_cause, 0);
    check("rst_resume", resume_addr, 0);
    check("rst_done", xfer_done, 0);
    rst_n = 1'b1;
    tick();

    foreach (vt[i]) begin
      if (vt[i].k != 0) sb.push_back('{1'b0, 2'b01, vt[i].res});
      start(vt[i].first, vt[i].pg, vt[i].bt, vt[i].len, 1'b1);
      k = 0;
      for (int c = 1; c <= 48 && k == 0; c++) begin
        tick();
        if (split_req) k = c;
      end
      check($sformatf("v%0d_latency", i), k, vt[i].k);
      if (k != 0) begin
        ack();
      end else begin
        sb.delete();
        sb.push_back('{1'b1, 2'b00, 32'h0});
        ce_n_ip = 1'b1;
        tick();
        ce_n_ip = 1'b0;
        tick();
      end
    end

    // tCEM with SCLK stopped: resume backs off one beat; held until ack.
    start(32'h100, 4'd9, 2'b01, 10'd32, 1'b1);
    tick();
    tick();
    tcem_expired = 1'b1;
    sclk_en = 1'b0;
    sb.push_back('{1'b0, 2'b10, 32'h106});
    tick();
    tcem_expired = 1'b0;
    sclk_en = 1'b1;
    check("tcem_req", split_req, 1);
    for (int i = 0; i < 5; i++) begin
      start_track = (i == 1);
      first_addr = 32'h7C;
      mem_page_size = 4'd7;
      tick();
      check("hold_req", split_req, 1);
      check("hold_resume", resume_addr, 32'h106);
    end
    start_track = 1'b0;
    ack();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("split_start_ignored", split_req, 0);
    end

    // tCEM coincident with a page hit.
    start(32'h1FC, 4'd9, 2'b01, 10'd32, 1'b1);
    tcem_expired = 1'b1;
    sb.push_back('{1'b0, 2'b11, 32'h200});
    tick();
    tcem_expired = 1'b0;
    check("both_req", split_req, 1);
    ack();

    // CE# rises during TRACK.
    start(32'h100, 4'd9, 2'b01, 10'd32, 1'b1);
    tick();
    ce_n_ip = 1'b1;
    sb.push_back('{1'b1, 2'b00, 32'h0});
    tick();
    ce_n_ip = 1'b0;
    check("done_pulse", xfer_done, 1);
    tick();
    check("done_clear", xfer_done, 0);
    check("ce_no_split", split_req, 0);

    // CE# rises while a split is pending.
    sb.push_back('{1'b0, 2'b01, 32'h80});
    start(32'h7C, 4'd7, 2'b01, 10'd32, 1'b1);
    tick();
    check("ce_split_req", split_req, 1);
    ce_n_ip = 1'b1;
    tick();
    ce_n_ip = 1'b0;
    check("ce_split_drop", split_req, 0);
    check("ce_split_nodone", xfer_done, 0);

    // Reset while in SPLIT.
    sb.push_back('{1'b0, 2'b01, 32'h80});
    start(32'h7C, 4'd7, 2'b01, 10'd32, 1'b1);
    tick();
    check("rst_split_req", split_req, 1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_req", split_req, 0);
    check("rst_mid_cause", split_cause, 0);
    check("rst_mid_resume", resume_addr, 0);
    rst_n = 1'b1;
    tick();

    // Read transfer.
`ifdef RD_TRACK_EN
    sb.push_back('{1'b0, 2'b10, 32'h82});
`endif
    start(32'h7C, 4'd7, 2'b01, 10'd32, 1'b0);
    tick();
    check("rd_no_page", split_req, 0);
    tcem_expired = 1'b1;
    tick();
    tcem_expired = 1'b0;
`ifdef RD_TRACK_EN
    check("rd_tcem_req", split_req, 1);
    ack();
`else
    check("rd_ignored", split_req, 0);
    tick();
    check("rd_ignored_late", split_req, 0);
`endif

    tick();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
